cache_arbiter: RTL and testbench
================================

// Module: cache_arbiter
// PURPOSE
// - Shares one physical-memory port between the I-cache and D-cache miss/writeback paths.
// - Sits between the two caches feeding the mp3 CPU's port a and port b and the line-wide pmem.
// - Serialises requests, holds one grant until pmem_resp, then returns a one-line response.
// PARAMETERS
// - LINE_W   256   cache line width in bits (pmem data width)
// - ADDR_W   32    byte address width
// PORTS
// - clk            in   1       system clock
// - reset          in   1       synchronous, active-high reset
// - i_read         in   1       I-cache line read request (held until i_resp)
// - i_address      in   ADDR_W  I-cache line address
// - i_rdata        out  LINE_W  line returned to I-cache
// - i_resp         out  1       I-cache completion, one-cycle pulse
// - d_read         in   1       D-cache line read request (held until d_resp)
// - d_write        in   1       D-cache writeback request (held until d_resp)
// - d_address      in   ADDR_W  D-cache line address
// - d_wdata        in   LINE_W  D-cache writeback data
// - d_rdata        out  LINE_W  line returned to D-cache
// - d_resp         out  1       D-cache completion, one-cycle pulse
// - pmem_read      out  1       pmem read command
// - pmem_write     out  1       pmem write command
// - pmem_address   out  ADDR_W  pmem address
// - pmem_wdata     out  LINE_W  pmem write data
// - pmem_rdata     in   LINE_W  pmem read data, valid with pmem_resp
// - pmem_resp      in   1       pmem completion pulse
// BEHAVIOUR
// - FSM states: IDLE, SERVE_I, SERVE_D, DONE. Reset -> IDLE; all outputs 0 in IDLE and DONE.
// - IDLE: i only -> SERVE_I; d only -> SERVE_D; both -> priority winner; none -> stay.
// - SERVE_I: pmem_read=1, pmem_address=i_address. SERVE_D: pmem_read=d_read, pmem_write=d_write,
//   pmem_address=d_address, pmem_wdata=d_wdata. Commands are a pure decode of state plus the
//   granted requester's held inputs.
// - Latency: request seen in IDLE at cycle N -> pmem command asserted at N+1.
// - On pmem_resp in SERVE_x: x_resp=1 the same cycle; x_rdata=pmem_rdata (read); next state DONE.
// - DONE lasts one cycle with no grant, so a request still high on the resp edge is not re-issued.
//   It then returns to IDLE. Back-to-back service costs resp + 2 cycles.
// - i_rdata/d_rdata carry pmem_rdata unconditionally; they are meaningful only with x_resp.
// - pmem_resp in IDLE or DONE is ignored. No resp pulses are generated outside SERVE_x.
// - d_read and d_write together are illegal: treated as a write, with a simulation-only assertion.
// - Grant never changes while in SERVE_x, whatever the other requester does.
// - Reset mid-transaction: next cycle IDLE, pmem commands drop and the transaction is abandoned.
//   A late pmem_resp is ignored.
// - Default priority (macro absent): D wins every conflict.
// CONFIGURATION
// - Macro ARB_ROUND_ROBIN_EN.
// - Defined: 1-bit last_grant register, updated when entering SERVE_x and reset to I.
//   On a conflict, the requester not served last wins. The first conflict after reset goes to D.
// - Undefined: no last_grant register; fixed D-over-I priority.
// STRUCTURE
// - Package arb_types: arb_state_t enum {IDLE, SERVE_I, SERVE_D, DONE}, arb_grant_t enum {GNT_I, GNT_D},
//   localparam LINE_W_DEFAULT = 256.
// - Sub-module arb_prio: combinational conflict resolver.
//   Inputs i_req, d_req, last_grant; output arb_grant_t.
//   Holds the ARB_ROUND_ROBIN_EN selection.
// - The FSM and output decode stay in cache_arbiter.
// TESTING
// - I only: i_read=1, i_address=0x0000_0060, pmem_resp after 3 cycles with rdata=0xA5..A5
//   -> pmem_read=1 from N+1, i_resp pulse with i_rdata=0xA5..A5, DONE, then IDLE.
// - D writeback: d_write=1, d_address=0x0000_1000, d_wdata=0x1234.. -> pmem_write=1 with that
//   address/data; d_resp pulses once; pmem_read stays 0.
// - Conflict: i_read and d_read rise together at cycle 10 -> D served first, I served immediately
//   after D's DONE. With ARB_ROUND_ROBIN_EN, a second simultaneous conflict -> I served first.
// - Held request: d_read kept high for 1 cycle after d_resp -> no second pmem_read issued (DONE masks).
// - Reset mid-op: reset=1 during SERVE_I before pmem_resp -> next cycle pmem_read=0, i_resp=0, IDLE.
//   A pmem_resp arriving 2 cycles later -> no resp pulse.
// - Stray pmem_resp in IDLE -> i_resp=d_resp=0, state stays IDLE.

Source files
------------

// File: rtl/arb_types.sv
// rtl/arb_types.sv - shared types for the I/D cache to pmem arbiter
package arb_types;

    localparam int LINE_W_DEFAULT = 256;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        DONE
    } arb_state_t;

    typedef enum logic {
        GNT_I,
        GNT_D
    } arb_grant_t;

endpackage

// File: rtl/arb_prio.sv
// rtl/arb_prio.sv - I/D conflict resolver; ARB_ROUND_ROBIN_EN selects alternating priority
module arb_prio
    import arb_types::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  arb_grant_t last_grant,
    output arb_grant_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
    // On a conflict the requester not served last wins; otherwise whoever asks
    always_comb begin
        grant = GNT_I;
        if (i_req && d_req) begin
            grant = (last_grant == GNT_D) ? GNT_I : GNT_D;
        end else if (d_req) begin
            grant = GNT_D;
        end
    end
`else
    // Fixed priority: D wins every conflict, so only d_req matters
    logic unused_prio;
    assign unused_prio = i_req ^ (last_grant == GNT_D);

    always_comb begin
        grant = d_req ? GNT_D : GNT_I;
    end
`endif

endmodule

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - shares one line-wide pmem port between I-cache and D-cache (option ARB_ROUND_ROBIN_EN)
module cache_arbiter
    import arb_types::*;
#(
    parameter int LINE_W = LINE_W_DEFAULT,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t state_q, state_d;
    arb_grant_t grant;
    arb_grant_t prio_last;
    logic       d_req;

    assign d_req = d_read | d_write;

    // Read data is a straight wire; callers qualify it with their resp pulse
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    arb_prio u_prio (
        .i_req      (i_read),
        .d_req      (d_req),
        .last_grant (prio_last),
        .grant      (grant)
    );

`ifdef ARB_ROUND_ROBIN_EN
    arb_grant_t last_grant_q, last_grant_d;

    // Remember who was granted last; reset to I so the first conflict goes to D
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GNT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Capture the grant only on the IDLE -> SERVE_x transition
    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (i_read || d_req)) begin
            last_grant_d = grant;
        end
    end

    assign prio_last = last_grant_q;
`else
    assign prio_last = GNT_I;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and command decode; commands depend only on state and the granted inputs
    always_comb begin
        state_d      = state_q;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_read || d_req) begin
                    state_d = (grant == GNT_D) ? SERVE_D : SERVE_I;
                end
            end
            SERVE_I: begin
                pmem_read    = 1'b1;
                pmem_address = i_address;
                if (pmem_resp) begin
                    i_resp  = 1'b1;
                    state_d = DONE;
                end
            end
            SERVE_D: begin
                // An illegal read+write pair is treated as a write
                pmem_read    = d_read & ~d_write;
                pmem_write   = d_write;
                pmem_address = d_address;
                pmem_wdata   = d_wdata;
                if (pmem_resp) begin
                    d_resp  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                // One dead cycle so a request still held on the resp edge is not re-issued
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef SYNTHESIS
    // The D-cache must never ask for a read and a writeback at once
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(d_read && d_write))
                else $error("cache_arbiter: d_read and d_write asserted together");
        end
    end
`endif

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter (honours ARB_ROUND_ROBIN_EN)
module tb_cache_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_read, d_read, d_write, pmem_resp;
    logic [AW-1:0] i_address, d_address;
    logic [LW-1:0] d_wdata, pmem_rdata;
    logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
    logic          i_resp, d_resp, pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rd;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } cmd_t;

    typedef struct {
        logic          is_d;
        logic [LW-1:0] rdata;
        logic          chk_data;
    } resp_t;

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
        int            delay;
        logic          exp_read;
        logic          exp_write;
        logic [AW-1:0] exp_addr;
    } vec_t;

    cmd_t  cmd_q[$];
    resp_t resp_q[$];
    vec_t  vecs[4];

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        cmd_t c;
        c.rd = rd; c.wr = wr; c.addr = a; c.wdata = wd;
        cmd_q.push_back(c);
    endtask

    task automatic push_resp(input logic is_d, input logic [LW-1:0] rd, input logic chk_data);
        resp_t r;
        r.is_d = is_d; r.rdata = rd; r.chk_data = chk_data;
        resp_q.push_back(r);
    endtask

    // Monitor: every new pmem command and every resp pulse must match the scoreboard head
    logic  cmd_prev = 1'b0;
    logic  cmd_now;
    cmd_t  mc;
    resp_t mr;
    always @(negedge clk) begin
        cmd_now = pmem_read | pmem_write;
        if (cmd_now && !cmd_prev) begin
            chk("cmd_expected", LW'(cmd_q.size() != 0), LW'(1));
            if (cmd_q.size() != 0) begin
                mc = cmd_q.pop_front();
                chk("cmd_read", LW'(pmem_read), LW'(mc.rd));
                chk("cmd_write", LW'(pmem_write), LW'(mc.wr));
                chk("cmd_addr", LW'(pmem_address), LW'(mc.addr));
                if (mc.wr) chk("cmd_wdata", pmem_wdata, mc.wdata);
            end
        end
        cmd_prev = cmd_now;
        if (i_resp || d_resp) begin
            chk("resp_expected", LW'(resp_q.size() != 0), LW'(1));
            chk("resp_onehot", LW'(i_resp & d_resp), LW'(0));
            if (resp_q.size() != 0) begin
                mr = resp_q.pop_front();
                chk("resp_port_d", LW'(d_resp), LW'(mr.is_d));
                if (mr.chk_data) chk("resp_rdata", mr.is_d ? d_rdata : i_rdata, mr.rdata);
            end
        end
    end

    task automatic drop_all();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    endtask

    task automatic run_single(input vec_t v, input int idx);
        if (v.is_d) begin
            d_read = ~v.wr; d_write = v.wr; d_address = v.addr; d_wdata = v.wdata;
        end else begin
            i_read = 1'b1; i_address = v.addr;
        end
        push_cmd(v.exp_read, v.exp_write, v.exp_addr, v.wdata);
        push_resp(v.is_d, v.rdata, ~v.wr);
        step();
        chk($sformatf("v%0d_lat_read", idx), LW'(pmem_read), LW'(v.exp_read));
        chk($sformatf("v%0d_lat_write", idx), LW'(pmem_write), LW'(v.exp_write));
        chk($sformatf("v%0d_lat_addr", idx), LW'(pmem_address), LW'(v.exp_addr));
        repeat (v.delay - 1) step();
        pmem_resp = 1'b1; pmem_rdata = v.rdata;
        step();
        pmem_resp = 1'b0;
        drop_all();
        chk($sformatf("v%0d_done_cmd", idx), LW'(pmem_read | pmem_write), LW'(0));
        chk($sformatf("v%0d_done_resp", idx), LW'(i_resp | d_resp), LW'(0));
        step();
    endtask

    task automatic conflict(input logic d_first, input int idx);
        logic [LW-1:0] rd_i, rd_d;
        rd_i = {8{32'h1111_0000 + 32'(idx)}};
        rd_d = {8{32'hDDDD_0000 + 32'(idx)}};
        i_read = 1'b1; i_address = 32'h0000_0400;
        d_read = 1'b1; d_address = 32'h0000_8000;
        if (d_first) begin
            push_cmd(1'b1, 1'b0, 32'h0000_8000, '0); push_resp(1'b1, rd_d, 1'b1);
            push_cmd(1'b1, 1'b0, 32'h0000_0400, '0); push_resp(1'b0, rd_i, 1'b1);
        end else begin
            push_cmd(1'b1, 1'b0, 32'h0000_0400, '0); push_resp(1'b0, rd_i, 1'b1);
            push_cmd(1'b1, 1'b0, 32'h0000_8000, '0); push_resp(1'b1, rd_d, 1'b1);
        end
        step();
        chk($sformatf("c%0d_first_addr", idx), LW'(pmem_address),
            LW'(d_first ? 32'h0000_8000 : 32'h0000_0400));
        step();
        pmem_resp = 1'b1; pmem_rdata = d_first ? rd_d : rd_i;
        step();
        pmem_resp = 1'b0;
        if (d_first) d_read = 1'b0; else i_read = 1'b0;
        chk($sformatf("c%0d_done_cmd", idx), LW'(pmem_read), LW'(0));
        step();
        chk($sformatf("c%0d_idle_cmd", idx), LW'(pmem_read), LW'(0));
        step();
        chk($sformatf("c%0d_second_read", idx), LW'(pmem_read), LW'(1));
        chk($sformatf("c%0d_second_addr", idx), LW'(pmem_address),
            LW'(d_first ? 32'h0000_0400 : 32'h0000_8000));
        step();
        pmem_resp = 1'b1; pmem_rdata = d_first ? rd_i : rd_d;
        step();
        pmem_resp = 1'b0;
        drop_all();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic second_d_first;
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0060, '0, {8{32'hA5A5_A5A5}}, 3, 1'b1, 1'b0, 32'h0000_0060};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_1000, {8{32'h1234_5678}}, {8{32'hBAD0_BAD0}}, 2,
                    1'b0, 1'b1, 32'h0000_1000};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_2040, '0, {8{32'h5A5A_5A5A}}, 1, 1'b1, 1'b0, 32'h0000_2040};
        vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFE0, '0, {LW{1'b1}}, 4, 1'b1, 1'b0, 32'hFFFF_FFE0};
`ifdef ARB_ROUND_ROBIN_EN
        second_d_first = 1'b0;
`else
        second_d_first = 1'b1;
`endif
        reset = 1'b1; drop_all();
        i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_pmem_read", LW'(pmem_read), LW'(0));
        chk("rst_pmem_write", LW'(pmem_write), LW'(0));
        chk("rst_pmem_addr", LW'(pmem_address), LW'(0));
        chk("rst_resp", LW'(i_resp | d_resp), LW'(0));
        step();

        for (int k = 0; k < 4; k++) run_single(vecs[k], k);

        conflict(1'b1, 1);

        // D read held one cycle past d_resp must not be re-issued
        d_read = 1'b1; d_address = 32'h0000_3000;
        push_cmd(1'b1, 1'b0, 32'h0000_3000, '0);
        push_resp(1'b1, {8{32'h0F0F_0F0F}}, 1'b1);
        step();
        step();
        pmem_resp = 1'b1; pmem_rdata = {8{32'h0F0F_0F0F}};
        step();
        pmem_resp = 1'b0;
        chk("held_done_cmd", LW'(pmem_read), LW'(0));
        step();
        d_read = 1'b0;
        chk("held_idle_cmd", LW'(pmem_read), LW'(0));
        step();
        chk("held_no_reissue", LW'(pmem_read), LW'(0));

        conflict(second_d_first, 2);

        // Reset during SERVE_I abandons the transaction; late resp ignored
        i_read = 1'b1; i_address = 32'h0000_0080;
        push_cmd(1'b1, 1'b0, 32'h0000_0080, '0);
        step();
        chk("rst_mid_serving", LW'(pmem_read), LW'(1));
        step();
        reset = 1'b1; i_read = 1'b0;
        step();
        reset = 1'b0;
        chk("rst_mid_read", LW'(pmem_read), LW'(0));
        chk("rst_mid_resp", LW'(i_resp), LW'(0));
        step();
        step();
        pmem_resp = 1'b1; pmem_rdata = {8{32'hDEAD_BEEF}};
        #1;
        chk("late_resp_i", LW'(i_resp), LW'(0));
        chk("late_resp_d", LW'(d_resp), LW'(0));
        step();
        pmem_resp = 1'b0;
        chk("late_resp_idle", LW'(pmem_read | pmem_write), LW'(0));
        step();

        // Stray pmem_resp in IDLE
        pmem_resp = 1'b1;
        #1;
        chk("stray_resp", LW'(i_resp | d_resp), LW'(0));
        chk("stray_cmd", LW'(pmem_read | pmem_write), LW'(0));
        step();
        pmem_resp = 1'b0;
        chk("stray_stay_idle", LW'(pmem_read | pmem_write), LW'(0));
        step();
        step();

        chk("cmd_q_drained", LW'(cmd_q.size()), LW'(0));
        chk("resp_q_drained", LW'(resp_q.size()), LW'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
